// File: rtl/tx_frame_pkg.sv
// rtl/tx_frame_pkg.sv - shared types, constants and byte-wise CRC-16/KERMIT step for the TX framer
package tx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PHR,
        ST_PAYLOAD,
        ST_FCS
    } tx_state_e;

    localparam int          DEFAULT_PREAMBLE_BYTES = 4;
    localparam logic [7:0]  DEFAULT_SFD            = 8'hA7;
    localparam logic [7:0]  PREAMBLE_BYTE          = 8'h00;
    localparam logic [15:0] CRC_POLY_REFL          = 16'h8408;
    localparam logic [15:0] CRC_INIT               = 16'h0000;

    // Reflected CRC-16 (poly 0x1021), one whole byte, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fcs16_calc.sv
// rtl/fcs16_calc.sv - running CRC-16/KERMIT register, cleared per frame, updated per accepted byte
module fcs16_calc
    import tx_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_INIT;
        end else if (byte_en) begin
            crc_d = crc16_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tx_frame_builder.sv
// rtl/tx_frame_builder.sv - 802.15.4 PPDU framer to a nibble FIFO; FCS appended when TX_FRAME_FCS_EN is defined
module tx_frame_builder
    import tx_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 127,
    parameter int         PREAMBLE_BYTES = DEFAULT_PREAMBLE_BYTES,
    parameter logic [7:0] SFD_VALUE      = DEFAULT_SFD
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic [7:0] inData,
    input  logic       inValid,
    output logic       outReady,
    input  logic       inFifoFull,
    output logic [3:0] outNibble,
    output logic       outWriteEnable,
    output logic       outBusy,
    output logic       outDone,
    output logic       outError
);

`ifdef TX_FRAME_FCS_EN
    localparam int FCS_BYTES = 2;
`else
    localparam int FCS_BYTES = 0;
`endif

    tx_state_e  state_q, state_d;
    logic       phase_q, phase_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic [6:0] pay_cnt_q, pay_cnt_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;
    logic [6:0] frame_len_q, frame_len_d;
    logic [3:0] nib_q, nib_d;
    logic       we_q, we_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       last_q, last_d;

    logic [7:0] req_len;
    logic       len_bad;
    logic       idle_req;
    logic       start_ok;
    logic       start_bad;
    logic [7:0] src_byte;
    logic       src_ok;
    logic       byte_end;
    logic       ready;
    logic       acc;

    assign req_len   = {1'b0, inLength} + 8'(FCS_BYTES);
    assign len_bad   = (inLength == 7'd0) || (req_len > 8'(MAX_LEN));
    // busy_q also covers the cycle the final nibble is on the FIFO bus
    assign idle_req  = inStart && (state_q == ST_IDLE) && !busy_q;
    assign start_ok  = idle_req && !len_bad;
    assign start_bad = idle_req && len_bad;

`ifdef TX_FRAME_FCS_EN
    logic        fcs_idx_q, fcs_idx_d;
    logic [15:0] crc;

    fcs16_calc u_fcs16_calc (
        .clk     (inClock),
        .rst_n   (inReset),
        .clear   (start_ok),
        .byte_en (acc),
        .data    (inData),
        .crc     (crc)
    );
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hi_nib_d    = hi_nib_q;
        pay_cnt_d   = pay_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        frame_len_d = frame_len_q;
        nib_d       = nib_q;
        we_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = last_q;
        err_d       = start_bad;
        last_d      = 1'b0;
        src_byte    = PREAMBLE_BYTE;
        src_ok      = 1'b0;
        byte_end    = 1'b0;
`ifdef TX_FRAME_FCS_EN
        fcs_idx_d   = fcs_idx_q;
`endif

        if (last_q) begin
            busy_d = 1'b0;
        end

        // A fresh start emits its first nibble in the same cycle
        if (start_ok) begin
            state_d     = ST_PREAMBLE;
            phase_d     = 1'b0;
            pre_cnt_d   = 8'd0;
            pay_cnt_d   = inLength;
            frame_len_d = req_len[6:0];
            busy_d      = 1'b1;
`ifdef TX_FRAME_FCS_EN
            fcs_idx_d   = 1'b0;
`endif
        end

        case (state_d)
            ST_PREAMBLE: begin src_byte = PREAMBLE_BYTE;         src_ok = 1'b1;    end
            ST_SFD:      begin src_byte = SFD_VALUE;             src_ok = 1'b1;    end
            ST_PHR:      begin src_byte = {1'b0, frame_len_d};   src_ok = 1'b1;    end
            ST_PAYLOAD:  begin src_byte = inData;                src_ok = inValid; end
`ifdef TX_FRAME_FCS_EN
            ST_FCS:      begin src_byte = fcs_idx_d ? crc[15:8] : crc[7:0]; src_ok = 1'b1; end
`endif
            default:     begin src_byte = PREAMBLE_BYTE;         src_ok = 1'b0;    end
        endcase

        ready = (state_d == ST_PAYLOAD) && !phase_d && !inFifoFull;
        acc   = ready && inValid;

        if (!inFifoFull && (state_d != ST_IDLE)) begin
            if (phase_d) begin
                nib_d    = hi_nib_q;
                we_d     = 1'b1;
                phase_d  = 1'b0;
                byte_end = 1'b1;
            end else if (src_ok) begin
                nib_d    = src_byte[3:0];
                hi_nib_d = src_byte[7:4];
                we_d     = 1'b1;
                phase_d  = 1'b1;
            end
        end

        if (acc) begin
            pay_cnt_d = pay_cnt_d - 7'd1;
        end

        if (byte_end) begin
            case (state_d)
                ST_PREAMBLE: begin
                    if (pre_cnt_d == 8'(PREAMBLE_BYTES - 1)) begin
                        state_d = ST_SFD;
                    end else begin
                        pre_cnt_d = pre_cnt_d + 8'd1;
                    end
                end
                ST_SFD: state_d = ST_PHR;
                ST_PHR: state_d = ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (pay_cnt_d == 7'd0) begin
`ifdef TX_FRAME_FCS_EN
                        state_d   = ST_FCS;
                        fcs_idx_d = 1'b0;
`else
                        state_d   = ST_IDLE;
                        last_d    = 1'b1;
`endif
                    end
                end
`ifdef TX_FRAME_FCS_EN
                ST_FCS: begin
                    if (fcs_idx_d) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b1;
                    end else begin
                        fcs_idx_d = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            hi_nib_q    <= 4'd0;
            pay_cnt_q   <= 7'd0;
            pre_cnt_q   <= 8'd0;
            frame_len_q <= 7'd0;
            nib_q       <= 4'd0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hi_nib_q    <= hi_nib_d;
            pay_cnt_q   <= pay_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            frame_len_q <= frame_len_d;
            nib_q       <= nib_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

`ifdef TX_FRAME_FCS_EN
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            fcs_idx_q <= 1'b0;
        end else begin
            fcs_idx_q <= fcs_idx_d;
        end
    end
`endif

    assign outReady       = ready;
    assign outNibble      = nib_q;
    assign outWriteEnable = we_q;
    assign outBusy        = busy_q;
    assign outDone        = done_q;
    assign outError       = err_q;

endmodule

// File: tb/tb_tx_frame_builder.sv
// tb/tb_tx_frame_builder.sv - directed self-checking bench for tx_frame_builder
module tb_tx_frame_builder;

    localparam int PRE = 4;
`ifdef TX_FRAME_FCS_EN
    localparam int FCS_N = 2;
`else
    localparam int FCS_N = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] len = 7'd0;
    logic [7:0] data = 8'd0;
    logic       valid = 1'b0;
    logic       fifo_full = 1'b0;
    logic       ready;
    logic [3:0] nib;
    logic       we;
    logic       busy;
    logic       done;
    logic       err;

    tx_frame_builder dut (
        .inClock        (clk),
        .inReset        (rst_n),
        .inStart        (start),
        .inLength       (len),
        .inData         (data),
        .inValid        (valid),
        .outReady       (ready),
        .inFifoFull     (fifo_full),
        .outNibble      (nib),
        .outWriteEnable (we),
        .outBusy        (busy),
        .outDone        (done),
        .outError       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] pay[$];
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    int first_wr, last_wr, done_cyc, err_seen;

    function automatic logic [15:0] ref_crc();
        logic [15:0] c = 16'h0000;
        logic fb;
        foreach (pay[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pay[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b[3:0]);
        exp_q.push_back(b[7:4]);
    endtask

    task automatic build_exp();
        logic [15:0] c;
        exp_q.delete();
        for (int i = 0; i < PRE; i++) push_byte(8'h00);
        push_byte(8'hA7);
        push_byte(8'(pay.size() + FCS_N));
        foreach (pay[k]) push_byte(pay[k]);
        if (FCS_N == 2) begin
            c = ref_crc();
            push_byte(c[7:0]);
            push_byte(c[15:8]);
        end
    endtask

    task automatic run_frame(input string name, input int stall_at, input int stall_n,
                             input int gap_after, input int gap_n, input int abort_at);
        int  idx;
        int  gap_left;
        bit  acc;
        got_q.delete();
        first_wr = -1; last_wr = -1; done_cyc = -1; err_seen = 0;
        idx = 0; gap_left = 0; acc = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; len = 7'(pay.size()); valid = 1'b1; data = pay[0];
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #2;
                check({name, "_rst_we"}, we, 0);
                check({name, "_rst_busy"}, busy, 0);
                check({name, "_rst_rdy"}, ready, 0);
                check({name, "_rst_nib"}, nib, 0);
                valid = 1'b0; start = 1'b0; fifo_full = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            fifo_full = (stall_n > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_n);
            @(negedge clk);
            if (cyc > stall_at && cyc <= stall_at + stall_n && stall_n > 0) begin
                check({name, "_stall_we"}, we, 0);
                check({name, "_stall_hold"}, nib, got_q[$]);
            end
            if (we) begin
                got_q.push_back(nib);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (cyc == 1) check({name, "_busy_c1"}, busy, 1);
            if (done) begin
                done_cyc = cyc;
                check({name, "_busy_at_done"}, busy, 0);
            end
            if (err) err_seen++;
            acc = valid && ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) begin
                idx++;
                if (idx - 1 == gap_after) gap_left = gap_n + 1;
            end
            if (gap_left > 0) begin
                valid = 1'b0;
                gap_left--;
            end else begin
                valid = (idx < pay.size());
                data  = (idx < pay.size()) ? pay[idx] : 8'h00;
            end
        end
        fifo_full = 1'b0; valid = 1'b0;
        check({name, "_done_seen"}, done_cyc >= 0, 1);
        check({name, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[k]) begin
            if (k < got_q.size()) check($sformatf("%s_nib%0d", name, k), got_q[k], exp_q[k]);
        end
        check({name, "_first_wr"}, first_wr, 1);
        check({name, "_span"}, last_wr - first_wr + 1, exp_q.size() + stall_n + gap_n);
        check({name, "_done_cyc"}, done_cyc, last_wr + 1);
        check({name, "_no_err"}, err_seen, 0);
    endtask

    task automatic reject(input string name, input logic [6:0] l);
        @(posedge clk); #1;
        start = 1'b1; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_err"}, err, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_we"}, we, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, "_err_off"}, err, 0);
            check({name, "_idle_we"}, we, 0);
            check({name, "_idle_busy"}, busy, 0);
        end
    endtask

    task automatic load_scenario_a();
        pay.delete();
        pay.push_back(8'h5A);
`ifdef TX_FRAME_FCS_EN
        build_exp();
`else
        exp_q = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'hA, 4'h1, 4'h0, 4'hA, 4'h5};
`endif
    endtask

    task automatic load_digits();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        build_exp();
    endtask

    initial begin
        #12;
        check("reset_we", we, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_rdy", ready, 0);
        check("reset_nib", nib, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        load_scenario_a();
        run_frame("one_byte", -10, 0, -1, 0, -1);

        load_digits();
        run_frame("digits", -10, 0, -1, 0, -1);
`ifdef TX_FRAME_FCS_EN
        check("digits_phr_lo", got_q[10], 4'hB);
        check("digits_fcs0", got_q[got_q.size() - 4], 4'h9);
        check("digits_fcs1", got_q[got_q.size() - 3], 4'h8);
        check("digits_fcs2", got_q[got_q.size() - 2], 4'h1);
        check("digits_fcs3", got_q[got_q.size() - 1], 4'h2);
`else
        check("digits_phr_lo", got_q[10], 4'h9);
        check("digits_last", got_q[got_q.size() - 1], 4'h3);
`endif
        check("digits_phr_hi", got_q[11], 4'h0);

        load_digits();
        run_frame("stall", 16, 3, -1, 0, -1);

        load_digits();
        run_frame("gap", -10, 0, 2, 2, -1);

        reject("rej_len0", 7'd0);
`ifdef TX_FRAME_FCS_EN
        reject("rej_len127", 7'd127);
        reject("rej_len126", 7'd126);
`endif

        load_digits();
        run_frame("abort", -10, 0, -1, 0, 15);
        load_scenario_a();
        run_frame("after_rst", -10, 0, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
